// File: rtl/uart_imem_loader.sv
// uart_imem_loader: boot-time program loader for the single-cycle RV32I core.
// Receives an image over an 8N1 UART line, writes it word by word into the
// instruction memory write port, and holds the core in reset until the whole
// image has arrived intact.
//
// Frame on the wire: 0xA5, LEN_LO, LEN_HI, then LEN*4 payload bytes, each
// 32-bit word sent little-endian.
//
// Optional build macro UART_IMEM_LOADER_CSUM_EN: one extra byte after the
// payload must equal the XOR of all payload bytes before the core is released.
//
// Handshake: there is no backpressure. The internal receiver raises rx_valid
// (or rx_ferr on a bad stop bit) for exactly one cycle per frame, and the
// loader FSM consumes that byte in the same cycle. imem_we is a one-cycle
// strobe; imem_waddr/imem_wdata are valid while imem_we is high and hold
// their values otherwise.

module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_WORDS   = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     MAX_WORDS = 16'(IMEM_WORDS);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        rx_state;
  rx_state_t        rx_state_next;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_q;
  logic             rx_fall;
  logic [CNT_W-1:0] clk_cnt;
  logic             half_tick;
  logic             full_tick;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             rx_valid;
  logic             rx_ferr;

  assign rx_fall   = rx_q & ~rx_s2;
  assign half_tick = (clk_cnt == HALF_M1);
  assign full_tick = (clk_cnt == FULL_M1);

  // Receiver next state: a start edge is re-checked at mid-bit to reject glitches.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_fall) rx_state_next = R_START;
      R_START: if (half_tick) rx_state_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (full_tick && (bit_cnt == 3'd7)) rx_state_next = R_STOP;
      R_STOP:  if (full_tick) rx_state_next = R_IDLE;
      default: rx_state_next = R_IDLE;
    endcase
  end

  // Receiver registers: synchroniser, bit timing, shift register and byte strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_q     <= 1'b1;
      rx_state <= R_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= 3'd0;
      rx_shift <= 8'd0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_q     <= rx_s2;
      rx_state <= rx_state_next;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;

      // The counter restarts on every state change and on every full bit period.
      if ((rx_state == R_IDLE) || (rx_state != rx_state_next) || full_tick) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end

      if (rx_state == R_IDLE) begin
        bit_cnt <= 3'd0;
      end

      // Data arrives LSB first, so shift in from the top.
      if ((rx_state == R_DATA) && full_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if ((rx_state == R_STOP) && full_tick) begin
        if (rx_s2) begin
          rx_valid <= 1'b1;
        end else begin
          rx_ferr <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_LO    = 3'd1,
    S_LEN_HI    = 3'd2,
    S_DATA      = 3'd3,
`ifdef UART_IMEM_LOADER_CSUM_EN
    S_CSUM      = 3'd4,
`endif
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_word;
  logic [15:0] widx;
  logic [1:0]  bidx;
  logic [23:0] word_buf;
  logic        last_word;
`ifdef UART_IMEM_LOADER_CSUM_EN
  logic [7:0]  csum;
`endif

  assign len_word  = {rx_shift, len_lo};
  assign last_word = (widx == (len - 16'd1));

  // Loader next state: advances only on received bytes or framing errors.
  always_comb begin
    state_next = state;
    if (rx_ferr) begin
      // Noise before sync or after completion is harmless; anywhere else the image is suspect.
      if ((state != S_WAIT_SYNC) && (state != S_DONE)) begin
        state_next = S_ERROR;
      end
    end else if (rx_valid) begin
      case (state)
        S_WAIT_SYNC: if (rx_shift == SYNC_BYTE) state_next = S_LEN_LO;
        S_LEN_LO:    state_next = S_LEN_HI;
        S_LEN_HI: begin
          if ((len_word == 16'd0) || (len_word > MAX_WORDS)) begin
            state_next = S_ERROR;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          if ((bidx == 2'd3) && last_word) begin
`ifdef UART_IMEM_LOADER_CSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
          end
        end
`ifdef UART_IMEM_LOADER_CSUM_EN
        S_CSUM:      state_next = (rx_shift == csum) ? S_DONE : S_ERROR;
`endif
        S_DONE:      state_next = S_DONE;
        S_ERROR:     if (rx_shift == SYNC_BYTE) state_next = S_LEN_LO;
        default:     state_next = S_WAIT_SYNC;
      endcase
    end
  end

  // Loader state register and status outputs; the core leaves reset one cycle after DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_WAIT_SYNC;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_next;
      load_done  <= (state_next == S_DONE);
      load_err   <= (state_next == S_ERROR);
      core_rst_n <= (state == S_DONE);
    end
  end

  // Loader datapath: length capture, word assembly and the memory write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_lo     <= 8'd0;
      len        <= 16'd0;
      widx       <= 16'd0;
      bidx       <= 2'd0;
      word_buf   <= 24'd0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
`ifdef UART_IMEM_LOADER_CSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (rx_valid && !rx_ferr) begin
        case (state)
          S_LEN_LO: len_lo <= rx_shift;
          S_LEN_HI: begin
            // Every accepted header restarts the image at address 0.
            len  <= len_word;
            widx <= 16'd0;
            bidx <= 2'd0;
`ifdef UART_IMEM_LOADER_CSUM_EN
            csum <= 8'd0;
`endif
          end
          S_DATA: begin
            bidx <= bidx + 2'd1;
`ifdef UART_IMEM_LOADER_CSUM_EN
            csum <= csum ^ rx_shift;
`endif
            case (bidx)
              2'd0: word_buf[7:0]   <= rx_shift;
              2'd1: word_buf[15:8]  <= rx_shift;
              2'd2: word_buf[23:16] <= rx_shift;
              default: begin
                // Fourth byte completes the word; publish it with a one-cycle strobe.
                imem_we    <= 1'b1;
                imem_waddr <= widx[ADDR_W-1:0];
                imem_wdata <= {rx_shift, word_buf};
                widx       <= widx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: randomized bench for uart_imem_loader against a
// frame-level reference model (byte stream -> expected words and flags).
// Honours UART_IMEM_LOADER_CSUM_EN the same way the design does.
`timescale 1ns/1ps

module tb_uart_imem_loader;

  localparam int CPB   = 4;
  localparam int WORDS = 16;
  localparam int AW    = 4;

  localparam int PH_HUNT = 0;
  localparam int PH_LO   = 1;
  localparam int PH_HI   = 2;
  localparam int PH_PAY  = 3;
  localparam int PH_CSUM = 4;
  localparam int PH_DONE = 5;
  localparam int PH_ERR  = 6;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  uart_imem_loader #(
    .CLKS_PER_BIT(CPB),
    .IMEM_WORDS  (WORDS),
    .ADDR_W      (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] obs_q[$];
  int             obs_rd = 0;
  int             n_cmp  = 0;
  int             n_bad  = 0;
  logic [7:0]     tx_q[$];

  // Reference model state
  int         m_phase;
  int         m_len;
  logic [7:0] m_sum;
  logic [7:0] m_pay[$];
  bit         m_done;
  bit         m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: record every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (rst_n && imem_we) obs_q.push_back({imem_waddr, imem_wdata});
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    m_phase = PH_HUNT;
    m_len   = 0;
    m_sum   = 8'd0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_pay.delete();
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    logic [31:0] word;
    case (m_phase)
      PH_HUNT: if (b == 8'hA5) m_phase = PH_LO;
      PH_LO: begin
        m_len   = int'(b);
        m_phase = PH_HI;
      end
      PH_HI: begin
        m_len = m_len + 256 * int'(b);
        if (m_len == 0 || m_len > WORDS) begin
          m_phase = PH_ERR;
          m_err   = 1'b1;
        end else begin
          m_phase = PH_PAY;
          m_pay.delete();
          m_sum = 8'd0;
        end
      end
      PH_PAY: begin
        m_pay.push_back(b);
        m_sum = m_sum ^ b;
        if (m_pay.size() % 4 == 0) begin
          k    = m_pay.size() / 4 - 1;
          word = {m_pay[4*k+3], m_pay[4*k+2], m_pay[4*k+1], m_pay[4*k]};
          exp_q.push_back({AW'(k), word});
          if (k == m_len - 1) begin
`ifdef UART_IMEM_LOADER_CSUM_EN
            m_phase = PH_CSUM;
`else
            m_phase = PH_DONE;
            m_done  = 1'b1;
`endif
          end
        end
      end
      PH_CSUM: begin
        if (b == m_sum) begin
          m_phase = PH_DONE;
          m_done  = 1'b1;
        end else begin
          m_phase = PH_ERR;
          m_err   = 1'b1;
        end
      end
      PH_ERR: begin
        if (b == 8'hA5) begin
          m_phase = PH_LO;
          m_err   = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_ferr();
    if (m_phase != PH_HUNT && m_phase != PH_DONE) begin
      m_phase = PH_ERR;
      m_err   = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else model_ferr();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (stop_ok) repeat ($urandom_range(0, 3)) @(negedge clk);
    else repeat (CPB + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_list();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic push_s1();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h02); tx_q.push_back(8'h00);
    tx_q.push_back(8'h13); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    tx_q.push_back(8'h73); tx_q.push_back(8'h00); tx_q.push_back(8'h10); tx_q.push_back(8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", {imem_we, imem_waddr, imem_wdata, core_rst_n, load_done, load_err}, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Compare writes seen since the last call against the model, then the flags.
  task automatic check_state(input string tag);
    int n_obs;
    int n_exp;
    repeat (3) @(negedge clk);
    n_obs = obs_q.size() - obs_rd;
    n_exp = exp_q.size();
    check({tag, "_nwrites"}, 64'(n_obs), 64'(n_exp));
    for (int i = 0; i < n_obs && i < n_exp; i++) begin
      check({tag, "_write"}, 64'(obs_q[obs_rd + i]), 64'(exp_q[i]));
    end
    obs_rd = obs_q.size();
    exp_q.delete();
    check({tag, "_load_done"}, 64'(load_done), 64'(m_done));
    check({tag, "_load_err"}, 64'(load_err), 64'(m_err));
    check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(m_done));
  endtask

  // Global time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // Basic two-word image, then a stray byte after DONE (checksum byte when enabled).
    push_s1(); tx_q.push_back(8'h70); send_list();
    check_state("s1");

    // Garbage and a line glitch before the sync byte.
    do_reset();
    tx_q.push_back(8'h00); tx_q.push_back(8'hFF); tx_q.push_back(8'h5A); send_list();
    glitch();
    check_state("s2_pre");
    push_s1(); tx_q.push_back(8'h70); send_list();
    check_state("s2");

    // Zero length, then recovery from ERROR with a fresh frame.
    do_reset();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h00); send_list();
    check_state("s3_err");
    tx_q.push_back(8'hA5); tx_q.push_back(8'h01); tx_q.push_back(8'h00);
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE); tx_q.push_back(8'hAD); tx_q.push_back(8'hDE);
    tx_q.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE); send_list();
    check_state("s3_recover");

    // Oversized length.
    do_reset();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h11); tx_q.push_back(8'h00); send_list();
    check_state("s4_len");

    // Framing error on the second payload byte.
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b0);
    check_state("s4_ferr");

    // Reset in the middle of a load, then a clean load.
    do_reset();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h02); tx_q.push_back(8'h00);
    tx_q.push_back(8'h13); tx_q.push_back(8'h00); send_list();
    do_reset();
    push_s1(); tx_q.push_back(8'h70); send_list();
    check_state("s5");

    // Wrong trailing byte (a checksum mismatch when enabled).
    do_reset();
    push_s1(); tx_q.push_back(8'h71); send_list();
    check_state("s6_bad");

    // Randomized frames: noise, glitches, odd lengths, bad checksums, framing errors.
    for (int it = 0; it < 8; it++) begin
      int         n;
      int         bad_at;
      int         sz;
      logic [7:0] b;
      logic [7:0] sum;
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        tx_q.push_back(b);
      end
      send_list();
      if ($urandom_range(0, 1) == 1) glitch();
      case ($urandom_range(0, 7))
        0:       n = 0;
        1:       n = $urandom_range(WORDS + 1, WORDS + 4);
        default: n = $urandom_range(1, WORDS);
      endcase
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'(n));
      tx_q.push_back(8'(n >> 8));
      sum = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
        b   = 8'($urandom_range(0, 255));
        sum = sum ^ b;
        tx_q.push_back(b);
      end
      tx_q.push_back(($urandom_range(0, 3) == 0) ? (sum ^ 8'h01) : sum);
      sz     = tx_q.size();
      bad_at = ($urandom_range(0, 4) == 0) ? $urandom_range(3, sz - 1) : -1;
      for (int i = 0; i < sz; i++) send_byte(tx_q[i], i != bad_at);
      tx_q.delete();
      check_state($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
